// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: state encoding and default sizing shared by the adder sequencer files
package adder_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_RESP} seq_state_t;
   localparam int SEQ_WIDTH = 32;
   localparam int SEQ_CNT_W = 16;
   localparam int SEQ_TIMEOUT = 1023;
endpackage

// File: rtl/adder_seq_window_counter.sv
// adder_seq_window_counter: loadable down-counter, last is high while the count sits at 1
module adder_seq_window_counter #(
   parameter int W = 16
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_i,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_value,
   output logic         last
);
   logic [W-1:0] count;
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) count <= '0;
      else if (load) count <= load_value;
      else if (dec && count != '0) count <= count - W'(1);
   end
   assign last = count == W'(1);
endmodule

// File: rtl/instrumented_adder_sequencer.sv
// instrumented_adder_sequencer: one-command-at-a-time driver/checker for an instrumented adder
// Optional WAIT timeout is built only when ADDER_SEQ_TIMEOUT_EN is defined.
module instrumented_adder_sequencer
   import adder_seq_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH,
   parameter int CNT_W = SEQ_CNT_W,
   parameter int TIMEOUT = SEQ_TIMEOUT
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [CNT_W-1:0] cmd_cycles,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   output logic             dut_run,
   input  logic             dut_done,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic [WIDTH-1:0] dut_count,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic [WIDTH-1:0] rsp_count,
   output logic             rsp_err,
   output logic             rsp_timeout
);
   seq_state_t state, state_n;
   logic accept, run_last, wait_expired, capture;
   assign accept = cmd_valid && cmd_ready;
   assign capture = state == S_WAIT && (dut_done || wait_expired);
   // The window length is held in the counter itself from accept until RUN starts.
   adder_seq_window_counter #(.W(CNT_W)) u_run_window (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .load       (accept),
      .dec        (state == S_RUN),
      .load_value (cmd_cycles == '0 ? CNT_W'(1) : cmd_cycles),
      .last       (run_last)
   );
`ifdef ADDER_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   adder_seq_window_counter #(.W(TW)) u_wait_window (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .load       (state == S_RUN && run_last),
      .dec        (state == S_WAIT),
      .load_value (TW'(TIMEOUT)),
      .last       (wait_expired)
   );
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) rsp_timeout <= 1'b0;
      else if (capture) rsp_timeout <= !dut_done;
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign wait_expired = 1'b0;
   assign rsp_timeout = 1'b0;
`endif
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: state_n = accept ? S_LOAD : S_IDLE;
         S_LOAD: state_n = S_RUN;
         S_RUN:  state_n = run_last ? S_WAIT : S_RUN;
         S_WAIT: state_n = capture ? S_RESP : S_WAIT;
         S_RESP: state_n = rsp_ready ? S_IDLE : S_RESP;
         default: state_n = S_IDLE;
      endcase
   end
   // Gating with reset drops the run enable inside the reset cycle itself.
   always_comb begin
      cmd_ready = state == S_IDLE && !wb_rst_i;
      dut_run = state == S_RUN && !wb_rst_i;
      rsp_valid = state == S_RESP;
   end
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         dut_a <= '0;
         dut_b <= '0;
         rsp_sum <= '0;
         rsp_count <= '0;
         rsp_err <= 1'b0;
      end else begin
         if (accept) begin
            dut_a <= cmd_a;
            dut_b <= cmd_b;
         end
         if (capture) begin
            rsp_sum <= dut_done ? dut_sum : '0;
            rsp_count <= dut_done ? dut_count : '0;
            rsp_err <= dut_done && dut_sum != dut_a + dut_b;
         end
      end
   end
endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// tb_instrumented_adder_sequencer: directed checks of the sequencer against hand-computed results
module tb_instrumented_adder_sequencer;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [15:0] cmd_cycles = '0;
   logic [31:0] dut_a, dut_b;
   logic        dut_run;
   logic        dut_done = 1'b0;
   logic [31:0] dut_sum = '0;
   logic [31:0] dut_count = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_sum, rsp_count;
   logic        rsp_err, rsp_timeout;
   int tests = 0;
   int fails = 0;
   always #5 wb_clk_i = ~wb_clk_i;
   instrumented_adder_sequencer #(.WIDTH(32), .CNT_W(16), .TIMEOUT(8)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_cycles  (cmd_cycles),
      .dut_a       (dut_a),
      .dut_b       (dut_b),
      .dut_run     (dut_run),
      .dut_done    (dut_done),
      .dut_sum     (dut_sum),
      .dut_count   (dut_count),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_sum     (rsp_sum),
      .rsp_count   (rsp_count),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout)
   );
   task automatic tick;
      @(posedge wb_clk_i);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [15:0] n);
      int k = 0;
      while (cmd_ready !== 1'b1 && k < 50) begin
         tick;
         k++;
      end
      chk("issue_ready", cmd_ready, 1);
      cmd_a = a;
      cmd_b = b;
      cmd_cycles = n;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
   endtask
   task automatic run_len(input string tag, input int exp);
      int k = 0;
      tick;
      while (dut_run === 1'b1 && k < 100) begin
         k++;
         tick;
      end
      chk(tag, k, exp);
   endtask
   task automatic finish_rsp(input string tag);
      chk({tag, "_ready_held"}, cmd_ready, 0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk({tag, "_ready_back"}, cmd_ready, 1);
      chk({tag, "_valid_drop"}, rsp_valid, 0);
   endtask
   initial begin
      int seen;
      tick;
      tick;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_dut_run", dut_run, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_dut_a", dut_a, 0);
      chk("rst_dut_b", dut_b, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_count", rsp_count, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      wb_rst_i = 1'b0;
      tick;
      chk("rel_cmd_ready", cmd_ready, 1);
      // normal run, done held high from the start (ignored outside WAIT)
      dut_done = 1'b1;
      dut_sum = 32'd12;
      dut_count = 32'd33;
      issue(32'd5, 32'd7, 16'd4);
      chk("load_run", dut_run, 0);
      chk("load_a", dut_a, 5);
      chk("load_b", dut_b, 7);
      chk("load_ready", cmd_ready, 0);
      run_len("n4_run_len", 4);
      chk("n4_wait_valid", rsp_valid, 0);
      tick;
      chk("n4_valid", rsp_valid, 1);
      chk("n4_sum", rsp_sum, 12);
      chk("n4_count", rsp_count, 33);
      chk("n4_err", rsp_err, 0);
      chk("n4_timeout", rsp_timeout, 0);
      finish_rsp("n4");
      // wrap-around, correct truncated sum
      dut_sum = 32'd0;
      issue(32'hFFFF_FFFF, 32'd1, 16'd2);
      run_len("wrap0_run_len", 2);
      tick;
      chk("wrap0_valid", rsp_valid, 1);
      chk("wrap0_sum", rsp_sum, 0);
      chk("wrap0_err", rsp_err, 0);
      finish_rsp("wrap0");
      // wrap-around, wrong sum
      dut_sum = 32'd1;
      issue(32'hFFFF_FFFF, 32'd1, 16'd2);
      run_len("wrap1_run_len", 2);
      tick;
      chk("wrap1_valid", rsp_valid, 1);
      chk("wrap1_sum", rsp_sum, 1);
      chk("wrap1_err", rsp_err, 1);
      finish_rsp("wrap1");
      // zero window behaves as one cycle
      dut_sum = 32'd3;
      issue(32'd1, 32'd2, 16'd0);
      run_len("n0_run_len", 1);
      tick;
      chk("n0_valid", rsp_valid, 1);
      chk("n0_err", rsp_err, 0);
      finish_rsp("n0");
      // late done, plus cmd_valid outside IDLE
      dut_done = 1'b0;
      dut_sum = 32'd100;
      dut_count = 32'd9;
      issue(32'd40, 32'd60, 16'd3);
      cmd_a = 32'd9;
      cmd_b = 32'd9;
      cmd_valid = 1'b1;
      run_len("late_run_len", 3);
      for (int i = 0; i < 3; i++) begin
         chk("late_no_valid", rsp_valid, 0);
         tick;
      end
      chk("late_a_kept", dut_a, 40);
      chk("late_b_kept", dut_b, 60);
      dut_done = 1'b1;
      tick;
      cmd_valid = 1'b0;
      chk("late_valid", rsp_valid, 1);
      chk("late_sum", rsp_sum, 100);
      chk("late_count", rsp_count, 9);
      chk("late_err", rsp_err, 0);
      finish_rsp("late");
      // backpressure: response must hold while the adder outputs move
      dut_sum = 32'd55;
      dut_count = 32'd7;
      issue(32'd50, 32'd5, 16'd1);
      run_len("bp_run_len", 1);
      tick;
      chk("bp_valid0", rsp_valid, 1);
      for (int i = 0; i < 10; i++) begin
         dut_sum = 32'd200 + 32'(i);
         dut_count = 32'(i);
         tick;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_sum", rsp_sum, 55);
         chk("bp_count", rsp_count, 7);
         chk("bp_err", rsp_err, 0);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      finish_rsp("bp");
`ifdef ADDER_SEQ_TIMEOUT_EN
      dut_done = 1'b0;
      dut_sum = 32'd77;
      dut_count = 32'd5;
      issue(32'd1, 32'd1, 16'd2);
      run_len("to_run_len", 2);
      for (int i = 0; i < 8; i++) begin
         chk("to_wait_no_valid", rsp_valid, 0);
         tick;
      end
      chk("to_valid", rsp_valid, 1);
      chk("to_timeout", rsp_timeout, 1);
      chk("to_sum", rsp_sum, 0);
      chk("to_count", rsp_count, 0);
      chk("to_err", rsp_err, 0);
      finish_rsp("to");
`endif
      // reset in the middle of RUN aborts silently
      dut_done = 1'b1;
      issue(32'd3, 32'd4, 16'd10);
      tick;
      tick;
      chk("mid_run_high", dut_run, 1);
      wb_rst_i = 1'b1;
      #1;
      chk("mid_run_drop", dut_run, 0);
      chk("mid_ready_in_rst", cmd_ready, 0);
      tick;
      wb_rst_i = 1'b0;
      #1;
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_dut_run", dut_run, 0);
      chk("mid_dut_a", dut_a, 0);
      tick;
      chk("mid_ready_back", cmd_ready, 1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick;
         if (rsp_valid === 1'b1 || dut_run === 1'b1) seen++;
      end
      chk("mid_no_response", seen, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instrumented_adder_sequencer.md
# instrumented_adder_sequencer

Command-driven initiator for the instrumented adder wrappers. It accepts one operand pair per command, drives the adder inputs, and holds the measurement run for a programmed window. It then waits for the adder's completion flag, captures the sum and ring count, checks the sum against the expected result, and returns one response per command. It sits between a host register block and any `wrapped_instrumented_adder_*` and replaces ad-hoc logic-analyzer bit-banging.

## Interface
Parameters:
- `WIDTH`, 32, operand/sum/count width
- `CNT_W`, 16, width of the measurement-window length
- `TIMEOUT`, 1023, maximum WAIT cycles (used only with the timeout feature)

Ports:
- `wb_clk_i`  in  1  single clock; all logic on the rising edge
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_a`  in  WIDTH  operand A
- `cmd_b`  in  WIDTH  operand B
- `cmd_cycles`  in  CNT_W  run-window length in cycles; 0 is treated as 1
- `dut_a`  out  WIDTH  registered operand A to the adder
- `dut_b`  out  WIDTH  registered operand B to the adder
- `dut_run`  out  1  enables the adder's ring/instrumentation
- `dut_done`  in  1  adder's chain-complete flag
- `dut_sum`  in  WIDTH  adder sum output
- `dut_count`  in  WIDTH  adder ring/cycle count
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  host consumes the response
- `rsp_sum`  out  WIDTH  captured sum
- `rsp_count`  out  WIDTH  captured count
- `rsp_err`  out  1  sum ≠ (A+B) mod 2^WIDTH
- `rsp_timeout`  out  1  WAIT expired

## Operation
FSM states are IDLE, LOAD, RUN, WAIT and RESP.
- **IDLE**
  - `cmd_ready` is 1 only in this state.
  - On `cmd_valid && cmd_ready`, latch A, B and the window length (0 becomes 1), then go to LOAD.
- **LOAD**
  - `dut_a` and `dut_b` carry the new operands and `dut_run` is 0.
  - Lasts 1 cycle; load the window counter, then go to RUN.
- **RUN**
  - `dut_run` is 1 for exactly N cycles; the window counter decrements each cycle.
  - At count 1, go to WAIT.
- **WAIT**
  - `dut_run` is 0 and `dut_done` is sampled every cycle.
  - When `dut_done` is 1, capture `dut_sum` and `dut_count`, compute `rsp_err`, then go to RESP.
- **RESP**
  - `rsp_valid` is 1 and all `rsp_*` outputs hold stable until `rsp_ready`.
  - On the handshake, go to IDLE. `cmd_ready` returns the following cycle, so there is no back-to-back accept.

Arithmetic:
- The expected sum is the WIDTH-bit truncated A+B; the carry is discarded.
- `rsp_err` is forced to 0 when `rsp_timeout` is 1.

Reset:
- Return to IDLE.
- `cmd_ready` becomes 1 one cycle after reset is released.
- `dut_a`, `dut_b`, `dut_run`, `rsp_valid`, `rsp_sum`, `rsp_count`, `rsp_err` and `rsp_timeout` are all 0.
- Reset in any state aborts the command with no response; `dut_run` drops in the reset cycle.

Boundaries:
- `cmd_valid` outside IDLE is ignored.
- `dut_done` outside WAIT is ignored.
- `dut_done` already high on WAIT entry is captured in the first WAIT cycle.

## Timing
- Accept in cycle t; LOAD at t+1; RUN from t+2 to t+1+N; WAIT from t+2+N.
- If `dut_done` is 1 at t+2+N, `rsp_valid` is 1 at t+3+N. Minimum command-to-response latency is therefore N+3 cycles.
- The response handshake happens in cycle r; `cmd_ready` is 1 at r+1.

## Configuration
Macro: `ADDER_SEQ_TIMEOUT_EN`.
- **Defined:** a WAIT counter starts from 0 on WAIT entry. If TIMEOUT cycles pass without `dut_done`, go to RESP with `rsp_timeout`=1, `rsp_sum`=0, `rsp_count`=0 and `rsp_err`=0. If `dut_done` arrives in the same cycle as expiry, `dut_done` wins.
- **Undefined:** WAIT is unbounded, `rsp_timeout` is tied to 0, and the counter logic is absent.

## Structure
- Package `adder_seq_pkg` contains:
  - the state enum `seq_state_t`;
  - default constants `SEQ_WIDTH`=32, `SEQ_CNT_W`=16 and `SEQ_TIMEOUT`=1023.
- One sub-module, `adder_seq_window_counter`, provides a loadable down-counter with a terminal flag. It is used for the RUN window and, when enabled, for the WAIT timeout.

## Test plan
- Normal run: A=5, B=7, N=4, `dut_done` held high. Expect `dut_run` high for exactly 4 cycles, then `rsp_valid` at accept+7 with `rsp_sum`=12 and `rsp_err`=0.
- Wrap: A=0xFFFF_FFFF, B=1, with `dut_sum`=0. Expect `rsp_err`=0. Repeat with `dut_sum`=1 and expect `rsp_err`=1.
- Zero window: N=0. Expect `dut_run` high for exactly 1 cycle.
- Backpressure: hold `rsp_ready`=0 for 10 cycles while `dut_sum` changes. Expect the `rsp_*` outputs to stay stable, `cmd_ready`=0 throughout, and `cmd_ready`=1 one cycle after the handshake.
- Timeout (macro defined, TIMEOUT=8): `dut_done` never asserts. Expect `rsp_timeout`=1 and `rsp_sum`=0 after 8 WAIT cycles.
- Reset mid-RUN: assert `wb_rst_i` during RUN. Expect `dut_run` and `rsp_valid` at 0 and no response, with `cmd_ready`=1 one cycle after release.
